hssl_link_supervisor: RTL and testbench

Parametrised per-lane link supervisor for GTH-based HSSL links carrying spiNNlink frames. It sits beside the rx/tx control blocks and drives the GTH receiver resets and comma alignment that were previously tied off. It also holds each lane's frame multiplexer in reset until the lane is aligned. Loss of alignment, elastic-buffer errors, handshake timeouts and version mismatches trigger automatic per-lane recovery, and each recovery is counted.

---
 rtl/hssl_link_supervisor.sv | 145 ++++++++++++++
 tb/tb_hssl_link_supervisor.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/hssl_link_supervisor.sv
// Per-lane GTH link supervisor: alignment, handshake and buffer-reset recovery FSMs.
// Optional per-lane saturating error counters enabled by HSSL_LINK_ERR_CNT_EN.
module hssl_link_supervisor #(
  parameter int unsigned NUM_LANES     = 1,
  parameter int unsigned STABLE_CYCLES = 64,
  parameter int unsigned HS_TIMEOUT    = 65536,
  parameter int unsigned BUFRST_CYCLES = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_LANES-1:0]         rxbyteisaligned_in,
  input  logic [3*NUM_LANES-1:0]       rxbufstatus_in,
  input  logic [NUM_LANES-1:0]         handshake_complete_in,
  input  logic [NUM_LANES-1:0]         version_mismatch_in,
  input  logic                         err_clr_in,
  output logic [NUM_LANES-1:0]         rxbufreset_out,
  output logic [NUM_LANES-1:0]         rxcommaalignen_out,
  output logic [NUM_LANES-1:0]         mux_rst_out,
  output logic [NUM_LANES-1:0]         link_up_out,
  output logic                         all_up_out,
  output logic [3*NUM_LANES-1:0]       lane_state_out,
  output logic [CNT_W*NUM_LANES-1:0]   err_cnt_out
);

  // One shared per-lane timer serves the stable, handshake and buffer-reset phases.
  localparam int unsigned MAX_A   = (STABLE_CYCLES > HS_TIMEOUT) ? STABLE_CYCLES : HS_TIMEOUT;
  localparam int unsigned MAX_CYC = (MAX_A > BUFRST_CYCLES) ? MAX_A : BUFRST_CYCLES;
  localparam int unsigned TMR_W   = $clog2(MAX_CYC);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_ALIGN     = 3'd1,
    ST_HANDSHAKE = 3'd2,
    ST_UP        = 3'd3,
    ST_BUFRST    = 3'd4
  } state_e;

  state_e             state_q [NUM_LANES];
  state_e             state_d [NUM_LANES];
  logic [TMR_W-1:0]   tmr_q   [NUM_LANES];
  logic [TMR_W-1:0]   tmr_d   [NUM_LANES];
  logic [NUM_LANES-1:0] err_ev_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= ST_RESET;
        tmr_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= state_d[i];
        tmr_q[i]   <= tmr_d[i];
      end
    end
  end

  // Timer returns to zero on every state change; error exits win over progress.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      state_d[i]  = state_q[i];
      tmr_d[i]    = '0;
      err_ev_c[i] = 1'b0;
      case (state_q[i])
        ST_RESET: state_d[i] = ST_ALIGN;
        ST_ALIGN: begin
          if (rxbufstatus_in[3*i+2]) begin
            state_d[i] = ST_BUFRST;
          end else if (rxbyteisaligned_in[i]) begin
            if (tmr_q[i] == TMR_W'(STABLE_CYCLES - 1)) state_d[i] = ST_HANDSHAKE;
            else                                       tmr_d[i]   = tmr_q[i] + TMR_W'(1);
          end
        end
        ST_HANDSHAKE: begin
          if (!rxbyteisaligned_in[i] || rxbufstatus_in[3*i+2] || version_mismatch_in[i] ||
              (tmr_q[i] == TMR_W'(HS_TIMEOUT - 1))) begin
            state_d[i] = ST_BUFRST;
          end else if (handshake_complete_in[i]) begin
            state_d[i] = ST_UP;
          end else begin
            tmr_d[i] = tmr_q[i] + TMR_W'(1);
          end
        end
        ST_UP: begin
          if (!rxbyteisaligned_in[i] || rxbufstatus_in[3*i+2] || !handshake_complete_in[i])
            state_d[i] = ST_BUFRST;
        end
        ST_BUFRST: begin
          if (tmr_q[i] == TMR_W'(BUFRST_CYCLES - 1)) state_d[i] = ST_ALIGN;
          else                                       tmr_d[i]   = tmr_q[i] + TMR_W'(1);
        end
        default: state_d[i] = ST_RESET;
      endcase
      err_ev_c[i] = (state_d[i] == ST_BUFRST) && (state_q[i] != ST_BUFRST);
    end
  end

  // Output decode straight from the state registers.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      rxbufreset_out[i]         = (state_q[i] == ST_BUFRST);
      rxcommaalignen_out[i]     = (state_q[i] == ST_RESET) || (state_q[i] == ST_ALIGN) ||
                                  (state_q[i] == ST_BUFRST);
      mux_rst_out[i]            = (state_q[i] == ST_RESET) || (state_q[i] == ST_ALIGN) ||
                                  (state_q[i] == ST_BUFRST);
      link_up_out[i]            = (state_q[i] == ST_UP);
      lane_state_out[3*i +: 3]  = state_q[i];
    end
  end

  assign all_up_out = &link_up_out;

`ifdef HSSL_LINK_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q [NUM_LANES];
  logic [CNT_W-1:0] err_cnt_d [NUM_LANES];

  // Saturating count of BUFRST entries; clear has priority.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      err_cnt_d[i] = err_cnt_q[i];
      if (err_clr_in)                            err_cnt_d[i] = '0;
      else if (err_ev_c[i] && (err_cnt_q[i] != '1)) err_cnt_d[i] = err_cnt_q[i] + CNT_W'(1);
      err_cnt_out[CNT_W*i +: CNT_W] = err_cnt_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LANES; i++) err_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) err_cnt_q[i] <= err_cnt_d[i];
    end
  end

  logic unused_in;
  assign unused_in = ^rxbufstatus_in;
`else
  assign err_cnt_out = '0;

  logic unused_in;
  assign unused_in = ^{rxbufstatus_in, err_clr_in, err_ev_c};
`endif

endmodule

// File: tb/tb_hssl_link_supervisor.sv
// Bench for hssl_link_supervisor: dwell-time model checked every cycle plus directed literal checks.
module tb_hssl_link_supervisor;
  localparam int unsigned NL = 2;
  localparam int unsigned ST = 64;
  localparam int unsigned HS = 100;
  localparam int unsigned BR = 16;
  localparam int unsigned CW = 2;
`ifdef HSSL_LINK_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic [NL-1:0]    aligned, hc, vm;
  logic [3*NL-1:0]  bufst;
  logic             clr;
  logic [NL-1:0]    rxbufreset_out, rxcommaalignen_out, mux_rst_out, link_up_out;
  logic             all_up_out;
  logic [3*NL-1:0]  lane_state_out;
  logic [CW*NL-1:0] err_cnt_out;

  always #5 clk = ~clk;

  hssl_link_supervisor #(
    .NUM_LANES(NL), .STABLE_CYCLES(ST), .HS_TIMEOUT(HS), .BUFRST_CYCLES(BR), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rxbyteisaligned_in(aligned), .rxbufstatus_in(bufst),
    .handshake_complete_in(hc), .version_mismatch_in(vm), .err_clr_in(clr),
    .rxbufreset_out(rxbufreset_out), .rxcommaalignen_out(rxcommaalignen_out),
    .mux_rst_out(mux_rst_out), .link_up_out(link_up_out), .all_up_out(all_up_out),
    .lane_state_out(lane_state_out), .err_cnt_out(err_cnt_out)
  );

  int vecs = 0;
  int miss = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each lane tracks its state code, cycles spent in it, and the aligned run length.
  int m_st [NL];
  int m_dwell [NL];
  int m_run [NL];
  int m_err [NL];
  int m_nxt;
  bit m_al, m_be, m_hc, m_vm;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int l = 0; l < NL; l++) begin
        m_st[l] = 0; m_dwell[l] = 0; m_run[l] = 0; m_err[l] = 0;
      end
    end else begin
      for (int l = 0; l < NL; l++) begin
        m_al = aligned[l]; m_be = bufst[3*l+2]; m_hc = hc[l]; m_vm = vm[l];
        m_nxt = m_st[l];
        case (m_st[l])
          0: m_nxt = 1;
          1: if (m_be) m_nxt = 4; else if (m_al && (m_run[l] + 1 >= ST)) m_nxt = 2;
          2: if (!m_al || m_be || m_vm || (m_dwell[l] + 1 >= HS)) m_nxt = 4;
             else if (m_hc) m_nxt = 3;
          3: if (!m_al || m_be || !m_hc) m_nxt = 4;
          4: if (m_dwell[l] + 1 >= BR) m_nxt = 1;
          default: m_nxt = 0;
        endcase
        if (m_nxt == 4 && m_st[l] != 4) m_err[l] = (m_err[l] == 3) ? 3 : m_err[l] + 1;
        if (clr) m_err[l] = 0;
        m_run[l]   = (m_nxt == 1 && m_st[l] == 1 && m_al) ? m_run[l] + 1 : 0;
        m_dwell[l] = (m_nxt == m_st[l]) ? m_dwell[l] + 1 : 0;
        m_st[l]    = m_nxt;
      end
    end
  end

  logic [3*NL-1:0]  e_state;
  logic [NL-1:0]    e_bufrst, e_comma, e_up;
  logic [CW*NL-1:0] e_err;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int l = 0; l < NL; l++) begin
        e_state[3*l +: 3]  = 3'(m_st[l]);
        e_bufrst[l]        = (m_st[l] == 4);
        e_comma[l]         = (m_st[l] == 0) || (m_st[l] == 1) || (m_st[l] == 4);
        e_up[l]            = (m_st[l] == 3);
        e_err[CW*l +: CW]  = ERR_EN ? CW'(m_err[l]) : '0;
      end
      chk("state", 64'(lane_state_out), 64'(e_state));
      chk("rxbufreset", 64'(rxbufreset_out), 64'(e_bufrst));
      chk("commaalignen", 64'(rxcommaalignen_out), 64'(e_comma));
      chk("mux_rst", 64'(mux_rst_out), 64'(e_comma));
      chk("link_up", 64'(link_up_out), 64'(e_up));
      chk("all_up", 64'(all_up_out), 64'(&e_up));
      chk("err_cnt", 64'(err_cnt_out), 64'(e_err));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int lane_st(input int l);
    return int'(lane_state_out[3*l +: 3]);
  endfunction

  task automatic wait_state(input int l, input int code, input int maxc, output int n);
    n = 0;
    while (lane_st(l) != code && n < maxc) begin
      tick(1);
      n++;
    end
    chk("wait_state", 64'(lane_st(l)), 64'(code));
  endtask

  int n;

  initial begin
    reset_n = 1'b0; aligned = '1; bufst = '0; hc = '1; vm = '0; clr = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    tick(2);
    chk("rst_state", 64'(lane_state_out), 64'd0);
    chk("rst_comma", 64'(rxcommaalignen_out), 64'd3);
    chk("rst_link_up", 64'(link_up_out), 64'd0);

    // Bring-up: both lanes up 66 edges after release
    reset_n = 1'b1;
    n = 0;
    while (link_up_out != 2'b11 && n < 200) begin tick(1); n++; end
    chk("bringup_cycles", 64'(n), 64'd66);
    chk("bringup_all_up", 64'(all_up_out), 64'd1);

    // Alignment flicker on lane 0 at ALIGN cycle 40
    hc = '0;
    reset_n = 1'b0; #2; reset_n = 1'b1;
    tick(41);
    aligned[0] = 1'b0;
    tick(1);
    aligned[0] = 1'b1;
    wait_state(0, 2, 200, n);
    chk("flicker_hs_cycles", 64'(n), 64'd64);
    hc = '1;
    tick(1);
    chk("flicker_up", 64'(link_up_out), 64'd3);

    // Loss of alignment in UP on lane 1
    aligned[1] = 1'b0;
    tick(1);
    aligned[1] = 1'b1;
    chk("loss_state1", 64'(lane_st(1)), 64'd4);
    chk("loss_link_up", 64'(link_up_out), 64'd1);
    chk("loss_all_up", 64'(all_up_out), 64'd0);
    chk("loss_err1", 64'(err_cnt_out[CW +: CW]), ERR_EN ? 64'd1 : 64'd0);
    n = 0;
    while (rxbufreset_out[1] && n < 100) begin n++; tick(1); end
    chk("bufrst_len", 64'(n), 64'd16);
    wait_state(1, 3, 200, n);
    chk("relink_all_up", 64'(all_up_out), 64'd1);

    // Handshake timeouts on lane 0 until the counter saturates
    hc[0] = 1'b0;
    tick(1);
    chk("hc_drop_state0", 64'(lane_st(0)), 64'd4);
    for (int r = 0; r < 3; r++) begin
      wait_state(0, 2, 200, n);
      n = 0;
      while (lane_st(0) == 2 && n < 300) begin n++; tick(1); end
      chk("hs_dwell", 64'(n), 64'd100);
    end
    chk("err_sat", 64'(err_cnt_out[0 +: CW]), ERR_EN ? 64'd3 : 64'd0);

    // Clear coincident with a BUFRST entry
    wait_state(0, 2, 200, n);
    tick(99);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr_state0", 64'(lane_st(0)), 64'd4);
    chk("clr_err", 64'(err_cnt_out), 64'd0);

    // Version mismatch beats handshake_complete
    wait_state(0, 2, 200, n);
    hc[0] = 1'b1; vm[0] = 1'b1;
    tick(1);
    vm[0] = 1'b0;
    chk("prio_state0", 64'(lane_st(0)), 64'd4);

    // Asynchronous reset in mid-BUFRST
    tick(5);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_state", 64'(lane_state_out), 64'd0);
    chk("arst_bufrst", 64'(rxbufreset_out), 64'd0);
    chk("arst_mux", 64'(mux_rst_out), 64'd3);
    chk("arst_comma", 64'(rxcommaalignen_out), 64'd3);
    chk("arst_all_up", 64'(all_up_out), 64'd0);
    chk("arst_err", 64'(err_cnt_out), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Buffer error beats the stable-count exit in ALIGN
    tick(64);
    bufst[2] = 1'b1;
    tick(1);
    bufst = '0;
    chk("bufst_state0", 64'(lane_st(0)), 64'd4);
    chk("bufst_state1", 64'(lane_st(1)), 64'd2);
    tick(20);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
